// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 2-flop input synchroniser,
// 3-sample majority voting per bit, optional parity, 1 or 2 stop bits, and a
// valid/ready output stage with framing, parity and sticky overrun flags.
module uart_rx_param #(
  parameter int CLK_PER_BIT = 100,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF  = CLK_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_samp_a;
  logic                 r_samp_b;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_pend;
  logic                 r_frm_pend;
  logic                 r_armed;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_fe;
  logic                 r_pe;
  logic                 r_ovr;

  logic w_rs;
  logic w_decide;
  logic w_wrap;
  logic w_bit;
  logic w_last_data;
  logic w_last_stop;
  logic w_par_exp;
  logic w_frame_err;
  logic w_done;

  assign w_rs        = r_sync2;
  assign w_decide    = (r_cnt == CNT_W'(HALF + 1));
  assign w_wrap      = (r_cnt == CNT_W'(CLK_PER_BIT - 1));
  // Majority of the two stored samples and the live third sample.
  assign w_bit       = (r_samp_a & r_samp_b) | (r_samp_a & w_rs) | (r_samp_b & w_rs);
  assign w_last_data = (r_bit_idx == IDX_W'(DATA_BITS - 1));
  assign w_last_stop = (STOP_BITS == 1) || r_stop_idx;
  // Even mode expects XOR of the data; odd mode its complement.
  assign w_par_exp   = (PARITY == 1) ? ~(^r_shift) : (^r_shift);
  // The final stop bit is folded in directly because it is decided in the
  // same cycle the frame completes.
  assign w_frame_err = r_frm_pend | ~w_bit;

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign frame_err  = r_fe;
  assign parity_err = r_pe;
  assign overrun    = r_ovr;
  assign busy       = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and frame-completion strobe.
  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_armed && !w_rs) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_decide && w_bit) begin
          w_state_next = S_IDLE;  // false start
        end else if (w_wrap) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_wrap && w_last_data) begin
          w_state_next = (PARITY == 0) ? S_STOP : S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_wrap) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_decide && w_last_stop) begin
          w_state_next = S_IDLE;
          w_done       = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Synchroniser, bit timing, sampling and frame assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_cnt      <= '0;
      r_samp_a   <= 1'b1;
      r_samp_b   <= 1'b1;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_par_pend <= 1'b0;
      r_frm_pend <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;

      // Counter is held at 0 in IDLE so the first START cycle sees 0.
      if (r_state == S_IDLE || w_state_next == S_IDLE || w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_cnt == CNT_W'(HALF - 1)) begin
        r_samp_a <= w_rs;
      end
      if (r_cnt == CNT_W'(HALF)) begin
        r_samp_b <= w_rs;
      end

      if (r_state == S_IDLE) begin
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
        r_par_pend <= 1'b0;
        r_frm_pend <= 1'b0;
        if (w_rs) begin
          r_armed <= 1'b1;
        end
      end

      if (r_state == S_DATA) begin
        if (w_decide) begin
          r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
        end
        if (w_wrap && !w_last_data) begin
          r_bit_idx <= r_bit_idx + 1'b1;
        end
      end

      if (r_state == S_PARITY && w_decide && (w_bit != w_par_exp)) begin
        r_par_pend <= 1'b1;
      end

      if (r_state == S_STOP) begin
        if (w_decide && !w_bit) begin
          r_frm_pend <= 1'b1;
        end
        if (w_wrap) begin
          r_stop_idx <= 1'b1;
        end
      end

      // A low final stop bit leaves us disarmed so a held break cannot retrigger.
      if (w_done) begin
        r_armed <= w_bit;
      end
    end
  end

  // Output holding register with valid/ready handshake and overrun tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_done) begin
      if (!r_valid || rx_ready) begin
        r_data  <= r_shift;
        r_fe    <= w_frame_err;
        r_pe    <= r_par_pend;
        r_valid <= 1'b1;
        if (r_valid) begin
          r_ovr <= 1'b0;  // the old frame was accepted this cycle
        end
      end else begin
        r_ovr <= 1'b1;    // previous frame still unaccepted: drop this one
      end
    end else if (r_valid && rx_ready) begin
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

endmodule
